// File: rtl/instr_decode_ctrl.sv
// -----------------------------------------------------------------------------
// instr_decode_ctrl
//   Multi-cycle instruction register and control FSM for a MIPS-subset core.
//   Accepts one instruction word from instruction memory, holds it in the
//   instruction register, splits the fields for the register file / Extend
//   unit, and sequences IF -> ID -> EXE -> MEM -> WB while pulsing the
//   datapath strobes.
//
//   Handshake: a word transfers on a rising edge where instr_valid and
//   instr_ready are both 1. instr_ready is 1 only while the FSM sits in IF and
//   is ready for a new word. instr_valid is ignored in every other state.
//
// Ports
//   CLK, Reset         clock (rising edge), asynchronous active-low reset
//   instr_valid/instr  instruction memory word and its valid flag
//   instr_ready        IR can accept a word (IF only)
//   rs, rt, rd, sa     register / shift-amount fields of IR
//   imm16              IR[15:0], to Extend.Data
//   ExtSel             1 = sign-extend, 0 = zero-extend
//   ALUOp              000 add, 001 sub, 010 and, 011 or, 100 sll
//   ALUSrcB            1 = extended immediate, 0 = rt data
//   RegDst             1 = rd, 0 = rt
//   RegWre, MemRd, MemWr, PCWre, Branch, Jump   one-cycle strobes
//   illegal_op         one-cycle pulse for an unknown opcode/funct
//   state              FSM state: IF=0 ID=1 EXE=2 MEM=3 WB=4 HALT=5
// -----------------------------------------------------------------------------
module instr_decode_ctrl #(
    parameter int         INSTR_W = 32,
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [4:0]         sa,
    output logic [15:0]        imm16,
    output logic               ExtSel,
    output logic [2:0]         ALUOp,
    output logic               ALUSrcB,
    output logic               RegDst,
    output logic               RegWre,
    output logic               MemRd,
    output logic               MemWr,
    output logic               PCWre,
    output logic               Branch,
    output logic               Jump,
    output logic               illegal_op,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        S_IF = 3'd0, S_ID = 3'd1, S_EXE = 3'd2,
        S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
    } state_t;

    // Instruction class: the FSM only needs to know which path to take.
    typedef enum logic [2:0] {
        C_R, C_IMM, C_LW, C_SW, C_BEQ, C_J, C_HALT, C_ILL
    } cls_t;

    state_t      r_state;
    cls_t        r_cls;
    // The opcode is folded into r_cls, so IR only keeps the field bits.
    logic [25:0] r_ir;
    logic        r_ready;
    logic        r_extsel, r_alusrcb, r_regdst;
    logic [2:0]  r_aluop;
    logic        r_regwre, r_memrd, r_memwr, r_pcwre, r_branch, r_jump, r_ill;

    cls_t        w_cls;
    logic        w_extsel, w_alusrcb, w_regdst;
    logic [2:0]  w_aluop;
    logic [5:0]  w_op, w_funct;
    logic        w_accept;

    assign w_op     = instr[31:26];
    assign w_funct  = instr[5:0];
    assign w_accept = instr_valid && r_ready;

    // Decode of the incoming word; captured into registers on accept so the
    // controls then reflect IR and stay stable for the whole instruction.
    always_comb begin
        w_cls     = C_ILL;
        w_extsel  = 1'b0;
        w_aluop   = 3'b000;
        w_alusrcb = 1'b0;
        w_regdst  = 1'b0;
        case (w_op)
            6'b000000: begin
                w_regdst = 1'b1;
                w_cls    = C_R;
                case (w_funct)
                    6'b100000: w_aluop = 3'b000;
                    6'b100010: w_aluop = 3'b001;
                    6'b100100: w_aluop = 3'b010;
                    6'b100101: w_aluop = 3'b011;
                    6'b000000: w_aluop = 3'b100;
                    default: begin
                        w_cls    = C_ILL;
                        w_regdst = 1'b0;
                    end
                endcase
            end
            6'b001000: begin w_cls = C_IMM; w_extsel = 1'b1; w_alusrcb = 1'b1; end
            6'b001101: begin w_cls = C_IMM; w_aluop = 3'b011; w_alusrcb = 1'b1; end
            6'b001100: begin w_cls = C_IMM; w_aluop = 3'b010; w_alusrcb = 1'b1; end
            6'b100011: begin w_cls = C_LW;  w_extsel = 1'b1; w_alusrcb = 1'b1; end
            6'b101011: begin w_cls = C_SW;  w_extsel = 1'b1; w_alusrcb = 1'b1; end
            6'b000100: begin w_cls = C_BEQ; w_extsel = 1'b1; w_aluop = 3'b001; end
            6'b000010: w_cls = C_J;
            HALT_OP:   w_cls = C_HALT;
            default:   w_cls = C_ILL;
        endcase
    end

    // Outputs are registered: each transition also loads the Moore outputs
    // of the state being entered, so strobes line up with the state value.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state   <= S_IF;
            r_cls     <= C_R;
            r_ir      <= '0;
            r_ready   <= 1'b0;
            r_extsel  <= 1'b0;
            r_aluop   <= 3'b000;
            r_alusrcb <= 1'b0;
            r_regdst  <= 1'b0;
            r_regwre  <= 1'b0;
            r_memrd   <= 1'b0;
            r_memwr   <= 1'b0;
            r_pcwre   <= 1'b0;
            r_branch  <= 1'b0;
            r_jump    <= 1'b0;
            r_ill     <= 1'b0;
        end else begin
            r_regwre <= 1'b0;
            r_memrd  <= 1'b0;
            r_memwr  <= 1'b0;
            r_pcwre  <= 1'b0;
            r_branch <= 1'b0;
            r_jump   <= 1'b0;
            r_ill    <= 1'b0;
            case (r_state)
                S_IF: begin
                    if (w_accept) begin
                        r_ir      <= instr[25:0];
                        r_cls     <= w_cls;
                        r_extsel  <= w_extsel;
                        r_aluop   <= w_aluop;
                        r_alusrcb <= w_alusrcb;
                        r_regdst  <= w_regdst;
                        r_ready   <= 1'b0;
                        r_state   <= S_ID;
                        // j and illegal words finish in ID.
                        r_jump    <= (w_cls == C_J);
                        r_ill     <= (w_cls == C_ILL);
                        r_pcwre   <= (w_cls == C_J) || (w_cls == C_ILL);
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_ID: begin
                    case (r_cls)
                        C_J, C_ILL: begin r_state <= S_IF; r_ready <= 1'b1; end
                        C_HALT:     r_state <= S_HALT;
                        default: begin
                            r_state  <= S_EXE;
                            r_branch <= (r_cls == C_BEQ);
                            r_pcwre  <= (r_cls == C_BEQ);
                        end
                    endcase
                end
                S_EXE: begin
                    case (r_cls)
                        C_BEQ: begin r_state <= S_IF; r_ready <= 1'b1; end
                        C_LW, C_SW: begin
                            r_state <= S_MEM;
                            r_memrd <= (r_cls == C_LW);
                            r_memwr <= (r_cls == C_SW);
                            r_pcwre <= (r_cls == C_SW);
                        end
                        default: begin
                            r_state  <= S_WB;
                            r_regwre <= 1'b1;
                            r_pcwre  <= 1'b1;
                        end
                    endcase
                end
                S_MEM: begin
                    if (r_cls == C_SW) begin
                        r_state <= S_IF;
                        r_ready <= 1'b1;
                    end else begin
                        r_state  <= S_WB;
                        r_regwre <= 1'b1;
                        r_pcwre  <= 1'b1;
                    end
                end
                S_WB: begin
                    r_state <= S_IF;
                    r_ready <= 1'b1;
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_IF;
            endcase
        end
    end

    assign instr_ready = r_ready;
    assign rs          = r_ir[25:21];
    assign rt          = r_ir[20:16];
    assign rd          = r_ir[15:11];
    assign sa          = r_ir[10:6];
    assign imm16       = r_ir[15:0];
    assign ExtSel      = r_extsel;
    assign ALUOp       = r_aluop;
    assign ALUSrcB     = r_alusrcb;
    assign RegDst      = r_regdst;
    assign RegWre      = r_regwre;
    assign MemRd       = r_memrd;
    assign MemWr       = r_memwr;
    assign PCWre       = r_pcwre;
    assign Branch      = r_branch;
    assign Jump        = r_jump;
    assign illegal_op  = r_ill;
    assign state       = r_state;

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_instr_decode_ctrl
//   Directed bench for instr_decode_ctrl. Each instruction pushes its
//   hand-written per-cycle control vector sequence into exp_q; the sequence is
//   then compared cycle by cycle against the DUT. Outputs are sampled 1 ns
//   after the rising edge, inputs are driven at the same point.
//   Vector layout: {state[2:0], instr_ready, RegWre, MemRd, MemWr, PCWre,
//                   Branch, Jump, illegal_op}
// -----------------------------------------------------------------------------
module tb_instr_decode_ctrl;

  logic        CLK;
  logic        Reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm16;
  logic        ExtSel;
  logic [2:0]  ALUOp;
  logic        ALUSrcB, RegDst;
  logic        RegWre, MemRd, MemWr, PCWre, Branch, Jump, illegal_op;
  logic [2:0]  state;

  instr_decode_ctrl dut (
    .CLK(CLK), .Reset(Reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .rs(rs), .rt(rt), .rd(rd), .sa(sa),
    .imm16(imm16), .ExtSel(ExtSel), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
    .RegDst(RegDst), .RegWre(RegWre), .MemRd(MemRd), .MemWr(MemWr),
    .PCWre(PCWre), .Branch(Branch), .Jump(Jump), .illegal_op(illegal_op),
    .state(state)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- scoreboard ----------------
  logic [10:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_pc = 0, n_rw = 0, n_mw = 0, n_mr = 0;

  wire [10:0] w_obs = {state, instr_ready, RegWre, MemRd, MemWr, PCWre,
                       Branch, Jump, illegal_op};

  // Strobe pulse counters, sampled mid-cycle.
  always @(negedge CLK) begin
    if (PCWre)  n_pc++;
    if (RegWre) n_rw++;
    if (MemWr)  n_mw++;
    if (MemRd)  n_mr++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [10:0] v(input logic [2:0] st, input logic rdy,
      input logic rw, input logic mr, input logic mw, input logic pc,
      input logic br, input logic jp, input logic il);
    return {st, rdy, rw, mr, mw, pc, br, jp, il};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a word for one edge; hold keeps instr_valid high afterwards.
  task automatic accept(input logic [31:0] word, input bit hold);
    check_eq("ready_before_accept", {31'd0, instr_ready}, 32'd1);
    instr       = word;
    instr_valid = 1'b1;
    tick();
    if (!hold) instr_valid = 1'b0;
  endtask

  // Compare queued vectors, one per cycle; stops on the last (IF) cycle.
  task automatic run_q(input string tag);
    logic [10:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq(tag, {21'd0, w_obs}, {21'd0, e});
      if (exp_q.size() > 0) tick();
    end
  endtask

  task automatic push_id_only();       exp_q.push_back(v(1,0,0,0,0,0,0,0,0)); endtask
  task automatic push_exe_quiet();     exp_q.push_back(v(2,0,0,0,0,0,0,0,0)); endtask
  task automatic push_wb();            exp_q.push_back(v(4,0,1,0,0,1,0,0,0)); endtask
  task automatic push_if();            exp_q.push_back(v(0,1,0,0,0,0,0,0,0)); endtask

  task automatic check_ctrl(input string tag, input logic es, input logic [2:0] op,
                            input logic sb, input logic dst);
    check_eq({tag, "_ExtSel"},  {31'd0, ExtSel},  {31'd0, es});
    check_eq({tag, "_ALUOp"},   {29'd0, ALUOp},   {29'd0, op});
    check_eq({tag, "_ALUSrcB"}, {31'd0, ALUSrcB}, {31'd0, sb});
    check_eq({tag, "_RegDst"},  {31'd0, RegDst},  {31'd0, dst});
  endtask

  int s_pc, s_rw, s_mw, s_mr;
  task automatic snap();
    s_pc = n_pc; s_rw = n_rw; s_mw = n_mw; s_mr = n_mr;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    Reset       = 1'b0;
    instr_valid = 1'b0;
    instr       = 32'd0;
    repeat (2) @(posedge CLK);
    #1;
    // Reset state: everything zero, including instr_ready.
    check_eq("rst_vec",   {21'd0, w_obs}, 32'd0);
    check_eq("rst_imm16", {16'd0, imm16}, 32'd0);
    check_ctrl("rst", 1'b0, 3'b000, 1'b0, 1'b0);
    Reset = 1'b1;
    check_eq("rel_ready_low", {31'd0, instr_ready}, 32'd0);
    tick();
    check_eq("rel_ready", {21'd0, w_obs}, {21'd0, v(0,1,0,0,0,0,0,0,0)});

    // T2 addi $1,$0,-1
    snap();
    accept(32'h2001FFFF, 1'b0);
    check_eq("addi_imm16", {16'd0, imm16}, 32'h0000FFFF);
    check_eq("addi_rt",    {27'd0, rt},    32'd1);
    check_ctrl("addi", 1'b1, 3'b000, 1'b1, 1'b0);
    push_id_only(); push_exe_quiet(); push_wb(); push_if();
    run_q("addi_seq");
    check_eq("addi_rw_cnt", n_rw - s_rw, 32'd1);

    // T3 ori $2,$0,0xFFFF
    accept(32'h3402FFFF, 1'b0);
    check_ctrl("ori", 1'b0, 3'b011, 1'b1, 1'b0);
    check_eq("ori_rt", {27'd0, rt}, 32'd2);
    push_id_only(); push_exe_quiet(); push_wb(); push_if();
    run_q("ori_seq");

    // T4 lw then sw back to back, instr_valid held high throughout.
    snap();
    accept(32'h8C230004, 1'b1);
    instr = 32'h8C230004;
    check_eq("lw_rs",    {27'd0, rs},    32'd1);
    check_eq("lw_rt",    {27'd0, rt},    32'd3);
    check_eq("lw_imm16", {16'd0, imm16}, 32'd4);
    check_ctrl("lw", 1'b1, 3'b000, 1'b1, 1'b0);
    push_id_only(); push_exe_quiet();
    exp_q.push_back(v(3,0,0,1,0,0,0,0,0));
    push_wb(); push_if();
    run_q("lw_seq");
    accept(32'hAC230008, 1'b0);
    check_eq("sw_imm16", {16'd0, imm16}, 32'd8);
    check_ctrl("sw", 1'b1, 3'b000, 1'b1, 1'b0);
    push_id_only(); push_exe_quiet();
    exp_q.push_back(v(3,0,0,0,1,1,0,0,0));
    push_if();
    run_q("sw_seq");
    check_eq("lwsw_pc_cnt", n_pc - s_pc, 32'd2);
    check_eq("lwsw_rw_cnt", n_rw - s_rw, 32'd1);
    check_eq("lwsw_mw_cnt", n_mw - s_mw, 32'd1);
    check_eq("lwsw_mr_cnt", n_mr - s_mr, 32'd1);

    // T5 illegal R-type funct, then a normal add.
    snap();
    accept(32'h0000003F, 1'b0);
    exp_q.push_back(v(1,0,0,0,0,1,0,0,1));
    push_if();
    run_q("ill_seq");
    check_eq("ill_rw_cnt", n_rw - s_rw, 32'd0);
    accept(32'h00221820, 1'b0);
    check_eq("add_rd", {27'd0, rd}, 32'd3);
    check_ctrl("add", 1'b0, 3'b000, 1'b0, 1'b1);
    push_id_only(); push_exe_quiet(); push_wb(); push_if();
    run_q("add_seq");

    // sll $2,$2,2
    accept(32'h00021080, 1'b0);
    check_eq("sll_sa", {27'd0, sa}, 32'd2);
    check_ctrl("sll", 1'b0, 3'b100, 1'b0, 1'b1);
    push_id_only(); push_exe_quiet(); push_wb(); push_if();
    run_q("sll_seq");

    // j: finishes in ID.
    accept(32'h08000010, 1'b0);
    check_ctrl("j", 1'b0, 3'b000, 1'b0, 1'b0);
    exp_q.push_back(v(1,0,0,0,0,1,0,1,0));
    push_if();
    run_q("j_seq");

    // beq: finishes in EXE.
    accept(32'h10220003, 1'b0);
    check_ctrl("beq", 1'b1, 3'b001, 1'b0, 1'b0);
    push_id_only();
    exp_q.push_back(v(2,0,0,0,0,1,1,0,0));
    push_if();
    run_q("beq_seq");

    // T1 reset mid-lw: async clear while in MEM, no RegWre ever for it.
    snap();
    accept(32'h8C230004, 1'b0);
    tick(); tick();
    check_eq("t1_in_mem", {21'd0, w_obs}, {21'd0, v(3,0,0,1,0,0,0,0,0)});
    #2;
    Reset = 1'b0;
    #1;
    check_eq("t1_async_vec", {21'd0, w_obs}, 32'd0);
    check_eq("t1_async_imm", {16'd0, imm16}, 32'd0);
    check_ctrl("t1_async", 1'b0, 3'b000, 1'b0, 1'b0);
    tick();
    Reset = 1'b1;
    tick();
    check_eq("t1_ready_back", {21'd0, w_obs}, {21'd0, v(0,1,0,0,0,0,0,0,0)});
    repeat (3) tick();
    check_eq("t1_rw_cnt", n_rw - s_rw, 32'd0);
    check_eq("t1_pc_cnt", n_pc - s_pc, 32'd0);

    // T6 HALT: sticky with instr_valid held high, released only by Reset.
    snap();
    accept(32'hFC000000, 1'b1);
    instr = 32'h2001FFFF;
    push_id_only();
    exp_q.push_back(v(5,0,0,0,0,0,0,0,0));
    run_q("halt_seq");
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("halt_hold", {21'd0, w_obs}, {21'd0, v(5,0,0,0,0,0,0,0,0)});
    end
    check_eq("halt_ir_held", {16'd0, imm16}, 32'd0);
    check_eq("halt_pc_cnt", n_pc - s_pc, 32'd0);
    instr_valid = 1'b0;
    Reset = 1'b0;
    #1;
    check_eq("halt_rst_state", {29'd0, state}, 32'd0);
    tick();
    Reset = 1'b1;
    tick();
    accept(32'h08000010, 1'b0);
    exp_q.push_back(v(1,0,0,0,0,1,0,1,0));
    push_if();
    run_q("post_halt_j");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
